irq_request_ctrl: RTL and testbench
===================================

Name: irq_request_ctrl

Overview:
- Upstream request-capture stage for the 4-bit `priority_encoder`.
- Turns raw request lines into sticky, maskable pending bits. `pend_o` drives the encoder's `i` input.
- Runs its own request/acknowledge/end-of-interrupt handshake toward a consumer: irq, latched vector, ack, eoi.
- Within one service cycle, the vector it selects always equals what `priority_encoder` reports as `o` for the same pending word.

Parameters:
- N, 4, number of request lines. The vector is fixed at 2 bits, so N must be ≤ 4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  raw request lines, synchronous to clk
- mask_we  in  1  mask register write strobe
- mask_din  in  N  mask write data (1 = line masked)
- ack  in  1  consumer accepts the current vector
- eoi  in  1  consumer finished servicing
- ovf_clr  in  1  clears the overflow flags
- pend_o  out  N  pend & ~mask; connects to priority_encoder `i`
- irq  out  1  interrupt request to consumer
- vec  out  2  index of the highest-priority line being offered
- busy  out  1  high in the SERV state
- ovf  out  N  sticky per-line lost-request flags

Behaviour:
- Reset, asynchronous on rst_n low, applies immediately:
  - req_q=0, pend=0, mask=0 (all lines enabled), ovf=0.
  - State=IDLE, irq=0, vec=0, busy=0, pend_o=0.
- Edge capture, at each clk edge:
  - req_q<=req; rise = req & ~req_q.
  - A line already high at reset release counts as a rising edge on the first edge.
  - pend[k] sets on rise[k].
- Overflow: if rise[k] arrives while pend[k]=1, ovf[k] sets. ovf_clr clears all ovf bits, but a same-cycle set wins over the clear.
- Mask:
  - mask_we loads mask_din on the clock edge.
  - Masking hides a bit from pend_o only; it does not clear pend.
  - pend_o is combinational from the registered pend and mask, with zero added latency.
- Priority: the highest set index of pend_o wins (bit N-1 highest), matching priority_encoder.
- FSM, three states:
  - IDLE: irq=0, busy=0. If pend_o≠0, latch vec = highest set index of pend_o, set irq=1, go to REQ. Otherwise stay.
  - REQ: irq=1, and vec is held stable even if the line is masked or a higher line rises meanwhile. On ack: clear pend[vec], irq<=0, busy<=1, go to SERV.
  - SERV: busy=1, irq=0. On eoi: busy<=0, go to IDLE.
- Handshake rules:
  - ack outside REQ is ignored. eoi outside SERV is ignored.
  - ack and eoi together in REQ: only ack takes effect.
- Latency:
  - The req rising edge is sampled at edge E. irq goes high after edge E+1.
  - After eoi at edge F, the next irq can rise no earlier than edge F+1; at least one IDLE cycle always occurs.
- Simultaneous set/clear on one bit at the ack edge: rise wins, so pend stays 1 and ovf is not set.
- Mid-operation reset: any state returns to IDLE at once, all pending and ovf are lost, and irq drops asynchronously.
- vec keeps its last value in IDLE/SERV. It is only meaningful while irq=1.

Test Plan:
- Reset with req=0, then pulse req=4'b0100 for one cycle: pend_o=0100 one edge after sampling, irq=1 and vec=2 one edge later; ack → pend_o=0000, busy=1; eoi → busy=0, state IDLE.
- req=4'b1010 rising in the same cycle: vec=3 first; after ack+eoi, irq reasserts with vec=1 following one IDLE cycle.
- Write mask=4'b1000, then raise req[3] and req[0]: pend_o=0001, vec=0. Clear the mask after servicing: pend_o=1000 and line 3 is serviced next.
- While in REQ with vec=1, raise req[3]: vec stays 1 until ack; line 3 is offered after eoi.
- Pulse req[2] twice before ack: ovf=0100. Pulse ovf_clr: ovf=0000. In addition, a rise on req[2] at the ack edge leaves pend[2]=1 with no ovf.
- Assert rst_n=0 mid-REQ: irq, busy and pend_o go to 0 without a clock edge. Holding req=0001 through reset release produces irq with vec=0 two edges later.

Source files
------------

// File: rtl/irq_request_ctrl.sv
// Request capture, masking and irq/ack/eoi handshake in front of priority_encoder.
// Sticky pending bits, per-line overflow flags, highest index wins.
module irq_request_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         mask_we,
   input  logic [N-1:0] mask_din,
   input  logic         ack,
   input  logic         eoi,
   input  logic         ovf_clr,
   output logic [N-1:0] pend_o,
   output logic         irq,
   output logic [1:0]   vec,
   output logic         busy,
   output logic [N-1:0] ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   state_t       state;
   logic [N-1:0] req_q;
   logic [N-1:0] pend;
   logic [N-1:0] mask;
   logic [N-1:0] rise;
   logic [N-1:0] clr;
   logic [N-1:0] ovf_set;
   logic         take;
   logic [1:0]   hi;

   assign rise   = req & ~req_q;
   assign pend_o = pend & ~mask;
   assign take   = (state == REQ) && ack;

   always_comb begin
      hi = 2'd0;
      for (int k = 0; k < N; k++) begin
         if (pend_o[k]) hi = 2'(k);
      end
   end

   // a rise landing on the bit being acknowledged re-arms it, not an overflow
   always_comb begin
      clr = '0;
      for (int k = 0; k < N; k++) begin
         clr[k] = take && (vec == 2'(k));
      end
   end

   assign ovf_set = rise & pend & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         pend  <= '0;
         mask  <= '0;
         ovf   <= '0;
      end else begin
         req_q <= req;
         pend  <= (pend & ~clr) | rise;
         ovf   <= (ovf_clr ? '0 : ovf) | ovf_set;
         if (mask_we) mask <= mask_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         irq   <= 1'b0;
         vec   <= 2'd0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|pend_o) begin
                  vec   <= hi;
                  irq   <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               if (ack) begin
                  irq   <= 1'b0;
                  busy  <= 1'b1;
                  state <= SERV;
               end
            end
            SERV: begin
               if (eoi) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               irq   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Directed bench for irq_request_ctrl: capture, mask, handshake,
// overflow and asynchronous reset, with hand-computed expectations.
module tb_irq_request_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       mask_we;
   logic [3:0] mask_din;
   logic       ack;
   logic       eoi;
   logic       ovf_clr;
   logic [3:0] pend_o;
   logic       irq;
   logic [1:0] vec;
   logic       busy;
   logic [3:0] ovf;

   int ncomp = 0;
   int nfail = 0;

   irq_request_ctrl #(.N(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .mask_we  (mask_we),
      .mask_din (mask_din),
      .ack      (ack),
      .eoi      (eoi),
      .ovf_clr  (ovf_clr),
      .pend_o   (pend_o),
      .irq      (irq),
      .vec      (vec),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input string tag, input logic [3:0] p,
                     input logic i, input logic [1:0] v,
                     input logic b);
      chk({tag, ".pend"}, 8'(pend_o), 8'(p));
      chk({tag, ".irq"}, 8'(irq), 8'(i));
      if (i) chk({tag, ".vec"}, 8'(vec), 8'(v));
      chk({tag, ".busy"}, 8'(busy), 8'(b));
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0; mask_we = 1'b0; mask_din = '0;
      ack = 1'b0; eoi = 1'b0; ovf_clr = 1'b0;
      #12;
      st("rst", 4'b0000, 1'b0, 2'd0, 1'b0);
      chk("rst.vec", 8'(vec), 8'd0);
      chk("rst.ovf", 8'(ovf), 8'd0);
      rst_n = 1'b1;
      tick();

      // single line 2
      req = 4'b0100; tick();
      st("t1.cap", 4'b0100, 1'b0, 2'd0, 1'b0);
      req = 4'b0000; tick();
      st("t1.irq", 4'b0100, 1'b1, 2'd2, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      st("t1.ack", 4'b0000, 1'b0, 2'd0, 1'b1);
      eoi = 1'b1; tick(); eoi = 1'b0;
      st("t1.eoi", 4'b0000, 1'b0, 2'd0, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      st("t1.ackidle", 4'b0000, 1'b0, 2'd0, 1'b0);

      // two lines at once
      req = 4'b1010; tick();
      st("t2.cap", 4'b1010, 1'b0, 2'd0, 1'b0);
      req = 4'b0000; tick();
      st("t2.irq3", 4'b1010, 1'b1, 2'd3, 1'b0);
      ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
      st("t2.ack3", 4'b0010, 1'b0, 2'd0, 1'b1);
      eoi = 1'b1; tick(); eoi = 1'b0;
      st("t2.idle", 4'b0010, 1'b0, 2'd0, 1'b0);
      tick();
      st("t2.irq1", 4'b0010, 1'b1, 2'd1, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;
      st("t2.done", 4'b0000, 1'b0, 2'd0, 1'b0);

      // masking
      mask_we = 1'b1; mask_din = 4'b1000; tick(); mask_we = 1'b0;
      req = 4'b1001; tick();
      st("t3.cap", 4'b0001, 1'b0, 2'd0, 1'b0);
      req = 4'b0000; tick();
      st("t3.irq0", 4'b0001, 1'b1, 2'd0, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;
      st("t3.hid", 4'b0000, 1'b0, 2'd0, 1'b0);
      mask_we = 1'b1; mask_din = 4'b0000; tick(); mask_we = 1'b0;
      st("t3.unmask", 4'b1000, 1'b0, 2'd0, 1'b0);
      tick();
      st("t3.irq3", 4'b1000, 1'b1, 2'd3, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;
      st("t3.done", 4'b0000, 1'b0, 2'd0, 1'b0);

      // vec held while a higher line arrives
      req = 4'b0010; tick();
      req = 4'b0000; tick();
      st("t4.irq1", 4'b0010, 1'b1, 2'd1, 1'b0);
      req = 4'b1000; tick();
      st("t4.hold", 4'b1010, 1'b1, 2'd1, 1'b0);
      req = 4'b0000; tick();
      st("t4.hold2", 4'b1010, 1'b1, 2'd1, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      st("t4.ack", 4'b1000, 1'b0, 2'd0, 1'b1);
      eoi = 1'b1; tick(); eoi = 1'b0;
      st("t4.idle", 4'b1000, 1'b0, 2'd0, 1'b0);
      tick();
      st("t4.irq3", 4'b1000, 1'b1, 2'd3, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;

      // overflow
      req = 4'b0100; tick();
      req = 4'b0000; tick();
      chk("t5.ovf0", 8'(ovf), 8'h0);
      req = 4'b0100; tick();
      chk("t5.ovf", 8'(ovf), 8'h4);
      req = 4'b0000; tick();
      ack = 1'b1; tick(); ack = 1'b0;
      st("t5.ack", 4'b0000, 1'b0, 2'd0, 1'b1);
      chk("t5.ovfkeep", 8'(ovf), 8'h4);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("t5.ovfclr", 8'(ovf), 8'h0);
      eoi = 1'b1; tick(); eoi = 1'b0;
      req = 4'b0100; tick();
      req = 4'b0000; tick();
      st("t5.irq2", 4'b0100, 1'b1, 2'd2, 1'b0);
      ack = 1'b1; req = 4'b0100; tick(); ack = 1'b0;
      st("t5.rearm", 4'b0100, 1'b0, 2'd0, 1'b1);
      chk("t5.noovf", 8'(ovf), 8'h0);
      req = 4'b0000; tick();
      req = 4'b0100; ovf_clr = 1'b1; tick();
      chk("t5.setwins", 8'(ovf), 8'h4);
      req = 4'b0000; tick(); ovf_clr = 1'b0;
      chk("t5.clr2", 8'(ovf), 8'h0);
      eoi = 1'b1; tick(); eoi = 1'b0;
      tick();
      st("t5.irq2b", 4'b0100, 1'b1, 2'd2, 1'b0);
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;

      // asynchronous reset mid-REQ
      req = 4'b0001; tick();
      req = 4'b0000; tick();
      st("t6.irq0", 4'b0001, 1'b1, 2'd0, 1'b0);
      req = 4'b0001;
      #2 rst_n = 1'b0;
      #1;
      st("t6.async", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      st("t6.cap", 4'b0001, 1'b0, 2'd0, 1'b0);
      tick();
      st("t6.irq", 4'b0001, 1'b1, 2'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
